// File: rtl/sram_frame_arbiter_if.sv
// Signal bundle between the frame arbiter, its display/renderer clients and the async SRAM pins.
// Handshake: a pixel write transfers on a rising edge where wr_valid and wr_ready are both high;
// wr_x/wr_y/wr_data must be stable while wr_valid is high, and wr_valid may not drop before that edge.
interface sram_frame_arbiter_if;
   logic        line_req;
   logic [9:0]  line_y;
   logic        line_done;
   logic        line_err;
   logic        fifo_we;
   logic [15:0] fifo_data;
   logic        fifo_full;
   logic        wr_valid;
   logic        wr_ready;
   logic [9:0]  wr_x;
   logic [9:0]  wr_y;
   logic [15:0] wr_data;
   logic        frame_done;
   logic        vblank;
   logic        flip_page;
   logic [19:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_out;
   logic        SRAM_DQ_oe;
   logic [15:0] SRAM_DQ_in;
   logic        SRAM_CE_N;
   logic        SRAM_UB_N;
   logic        SRAM_LB_N;
   logic        SRAM_OE_N;
   logic        SRAM_WE_N;

   modport slave (
      input  line_req, line_y, fifo_full, wr_valid, wr_x, wr_y, wr_data,
             frame_done, vblank, SRAM_DQ_in,
      output line_done, line_err, fifo_we, fifo_data, wr_ready, flip_page,
             SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
             SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N
   );

   modport master (
      output line_req, line_y, fifo_full, wr_valid, wr_x, wr_y, wr_data,
             frame_done, vblank, SRAM_DQ_in,
      input  line_done, line_err, fifo_we, fifo_data, wr_ready, flip_page,
             SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
             SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N
   );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Shares one async SRAM port between display line fetches (priority) and renderer pixel writes,
// and flips the front/back frame page during vertical blank.
module sram_frame_arbiter #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int ACC_CYC = 3
) (
   input  logic                Clk,
   input  logic                Reset_N,
   sram_frame_arbiter_if.slave bus,
   output logic [1:0]          dbg_state_o
);
   localparam int              CW       = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
   localparam logic [CW-1:0]   CYC_LAST = CW'(ACC_CYC - 1);
   localparam logic [9:0]      X_LAST   = 10'(H_RES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [9:0]      x_q, x_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic            line_pend_q, line_pend_d;
   logic [9:0]      line_y_q, line_y_d;
   logic [9:0]      wr_x_q, wr_x_d;
   logic [8:0]      wr_y_q, wr_y_d;
   logic [15:0]     wr_data_q, wr_data_d;
   logic            flip_q, flip_d;
   logic            flip_pend_q, flip_pend_d;
   logic            line_done_q, line_done_d;
   logic            line_err_q, line_err_d;

   logic            line_ok;
   logic            wr_ok;
   logic            wr_ready;

   assign line_ok  = (line_y_q < 10'(V_RES));
   assign wr_ok    = (bus.wr_x < 10'(H_RES)) && (bus.wr_y < 10'(V_RES));
   assign wr_ready = (state_q == IDLE) && !line_pend_q && !bus.line_req && !flip_pend_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q     <= IDLE;
         x_q         <= '0;
         cyc_q       <= '0;
         line_pend_q <= 1'b0;
         line_y_q    <= '0;
         wr_x_q      <= '0;
         wr_y_q      <= '0;
         wr_data_q   <= '0;
         flip_q      <= 1'b0;
         flip_pend_q <= 1'b0;
         line_done_q <= 1'b0;
         line_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         cyc_q       <= cyc_d;
         line_pend_q <= line_pend_d;
         line_y_q    <= line_y_d;
         wr_x_q      <= wr_x_d;
         wr_y_q      <= wr_y_d;
         wr_data_q   <= wr_data_d;
         flip_q      <= flip_d;
         flip_pend_q <= flip_pend_d;
         line_done_q <= line_done_d;
         line_err_q  <= line_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      cyc_d       = cyc_q;
      line_pend_d = line_pend_q;
      line_y_d    = line_y_q;
      wr_x_d      = wr_x_q;
      wr_y_d      = wr_y_q;
      wr_data_d   = wr_data_q;
      flip_d      = flip_q;
      flip_pend_d = flip_pend_q | bus.frame_done;
      line_done_d = 1'b0;
      line_err_d  = 1'b0;

      // Only one line fetch can be outstanding; a second request is reported, not queued.
      if (bus.line_req) begin
         if (line_pend_q || state_q == READ) begin
            line_err_d = 1'b1;
         end else begin
            line_pend_d = 1'b1;
            line_y_d    = bus.line_y;
         end
      end

      case (state_q)
         IDLE: begin
            cyc_d = '0;
            if (line_pend_q) begin
               state_d = READ;
               x_d     = '0;
            end else if (flip_pend_q && bus.vblank) begin
               flip_d      = ~flip_q;
               flip_pend_d = bus.frame_done;
            end else if (bus.wr_valid && wr_ready && wr_ok) begin
               state_d   = WRITE;
               wr_x_d    = bus.wr_x;
               wr_y_d    = bus.wr_y[8:0];
               wr_data_d = bus.wr_data;
            end
         end
         READ: begin
            if (!line_ok) begin
               line_done_d = 1'b1;
               line_pend_d = 1'b0;
               state_d     = IDLE;
            end else if (cyc_q != CYC_LAST) begin
               cyc_d = cyc_q + CW'(1);
            end else if (!bus.fifo_full) begin
               cyc_d = '0;
               if (x_q == X_LAST) begin
                  line_done_d = 1'b1;
                  line_pend_d = 1'b0;
                  state_d     = IDLE;
               end else begin
                  x_d = x_q + 10'd1;
               end
            end
         end
         WRITE: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d   = '0;
               state_d = IDLE;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode from the registered state, so reset releases the bus immediately.
   always_comb begin
      bus.SRAM_CE_N   = 1'b1;
      bus.SRAM_UB_N   = 1'b1;
      bus.SRAM_LB_N   = 1'b1;
      bus.SRAM_OE_N   = 1'b1;
      bus.SRAM_WE_N   = 1'b1;
      bus.SRAM_DQ_oe  = 1'b0;
      bus.SRAM_ADDR   = '0;
      bus.SRAM_DQ_out = wr_data_q;
      bus.fifo_we     = 1'b0;
      bus.fifo_data   = bus.SRAM_DQ_in;
      bus.wr_ready    = wr_ready;
      bus.line_done   = line_done_q;
      bus.line_err    = line_err_q;
      bus.flip_page   = flip_q;
      case (state_q)
         READ: begin
            if (line_ok) begin
               bus.SRAM_CE_N = 1'b0;
               bus.SRAM_UB_N = 1'b0;
               bus.SRAM_LB_N = 1'b0;
               bus.SRAM_OE_N = 1'b0;
               bus.SRAM_ADDR = {flip_q, line_y_q[8:0], x_q};
               bus.fifo_we   = (cyc_q == CYC_LAST) && !bus.fifo_full;
            end
         end
         WRITE: begin
            bus.SRAM_CE_N  = 1'b0;
            bus.SRAM_UB_N  = 1'b0;
            bus.SRAM_LB_N  = 1'b0;
            bus.SRAM_WE_N  = 1'b0;
            bus.SRAM_DQ_oe = 1'b1;
            bus.SRAM_ADDR  = {~flip_q, wr_y_q, wr_x_q};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter: write-vector table, line fetch sequences with a
// read-data scoreboard, page flip and asynchronous reset corner cases.
module tb_sram_frame_arbiter;
   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int ACC_CYC = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   sram_frame_arbiter_if bus ();

   sram_frame_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .ACC_CYC(ACC_CYC)) dut (
      .Clk         (clk),
      .Reset_N     (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   // SRAM contents: a fixed function of the address.
   function automatic logic [15:0] sram_model(input logic [19:0] a);
      return a[15:0] ^ {a[19:16], a[19:16], 8'h3C};
   endfunction
   assign bus.SRAM_DQ_in = sram_model(bus.SRAM_ADDR);

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Write-access monitor: one record per WE_N-low burst.
   typedef struct {
      logic [19:0] addr;
      logic [15:0] data;
      int          len;
   } wacc_t;
   wacc_t wr_obs_q[$];
   wacc_t cur;
   int    wr_rd_idx = 0;
   int    burst_err = 0;
   int    gap_err   = 0;
   logic  prev_we_low = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we_low = 1'b0;
      end else begin
         if (!bus.SRAM_WE_N) begin
            if (!prev_we_low) begin
               cur.addr = bus.SRAM_ADDR;
               cur.data = bus.SRAM_DQ_out;
               cur.len  = 1;
            end else begin
               cur.len++;
               if (bus.SRAM_ADDR != cur.addr || bus.SRAM_DQ_out != cur.data) burst_err++;
            end
            if (!bus.SRAM_DQ_oe || bus.SRAM_CE_N) burst_err++;
         end else if (prev_we_low) begin
            wr_obs_q.push_back(cur);
            if (!bus.SRAM_CE_N) gap_err++;
         end
         prev_we_low = !bus.SRAM_WE_N;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_write(input string name, input logic [19:0] addr, input logic [15:0] data);
      if (wr_rd_idx < wr_obs_q.size()) begin
         chk({name, "_addr"}, wr_obs_q[wr_rd_idx].addr, addr);
         chk({name, "_data"}, wr_obs_q[wr_rd_idx].data, data);
         chk({name, "_we_len"}, wr_obs_q[wr_rd_idx].len, ACC_CYC);
         wr_rd_idx++;
      end else begin
         chk({name, "_present"}, 0, 1);
      end
   endtask

   // Offers one write, returns the cycle (after the accepting edge) at which wr_ready is seen again.
   task automatic do_write(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d,
                           output int gap);
      int w;
      bus.wr_x = x;
      bus.wr_y = y;
      bus.wr_data = d;
      bus.wr_valid = 1'b1;
      w = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.wr_ready) break;
         w++;
      end
      chk("wr_handshake", bus.wr_ready, 1);
      tick();
      bus.wr_valid = 1'b0;
      gap = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.wr_ready) begin
            gap = i;
            break;
         end
      end
      tick();
   endtask

   // Issues line_req for y and follows the fetch cycle by cycle (cycle 1 = first READ cycle).
   task automatic run_line(input string name, input logic [9:0] y, input logic page,
                           input int full_start, input int full_len,
                           input int stall_px, input int stall_extra,
                           input int err_at, input int exp_done, output int hs_c);
      int n_px, pushes, done_c, err_c, err_cnt, time_err, addr_err, data_err, exp_cyc;
      logic [15:0] e;
      n_px = (y < V_RES) ? H_RES : 0;
      exp_q.delete();
      for (int k = 0; k < n_px; k++) exp_q.push_back(sram_model({page, y[8:0], 10'(k)}));
      pushes = 0; done_c = 0; err_c = 0; err_cnt = 0; hs_c = 0;
      time_err = 0; addr_err = 0; data_err = 0;
      bus.line_req = 1'b1;
      bus.line_y   = y;
      @(negedge clk);
      chk({name, "_wr_ready_on_req"}, bus.wr_ready, 0);
      tick();
      bus.line_req = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 3000 && done_c == 0; c++) begin
         #1;
         bus.fifo_full = (c >= full_start) && (c < full_start + full_len);
         bus.line_req  = (c == err_at);
         if (hs_c != 0) bus.wr_valid = 1'b0;
         @(negedge clk);
         if (bus.fifo_we) begin
            exp_cyc = ACC_CYC * (pushes + 1) + ((pushes >= stall_px) ? stall_extra : 0);
            if (c != exp_cyc) time_err++;
            if (bus.SRAM_ADDR != {page, y[8:0], 10'(pushes)}) addr_err++;
            if (exp_q.size() == 0) data_err++;
            else begin
               e = exp_q.pop_front();
               if (bus.fifo_data != e) data_err++;
            end
            pushes++;
         end
         if (bus.line_done) done_c = c;
         if (bus.line_err) begin
            err_c = c;
            err_cnt++;
         end
         if (bus.wr_valid && bus.wr_ready) hs_c = c;
         @(posedge clk);
      end
      #1;
      bus.fifo_full = 1'b0;
      bus.line_req  = 1'b0;
      if (hs_c != 0) bus.wr_valid = 1'b0;
      chk({name, "_pushes"}, pushes, n_px);
      chk({name, "_done_cycle"}, done_c, exp_done);
      chk({name, "_push_timing_errs"}, time_err, 0);
      chk({name, "_push_addr_errs"}, addr_err, 0);
      chk({name, "_push_data_errs"}, data_err, 0);
      chk({name, "_line_err_count"}, err_cnt, (err_at > 0) ? 1 : 0);
      chk({name, "_line_err_cycle"}, err_c, (err_at > 0) ? err_at + 1 : 0);
   endtask

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] data;
      logic        sram;
      logic [19:0] addr;
      int          gap;
   } wvec_t;
   wvec_t wv[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, hs_c;
      // Writes issued with flip_page=0, so they land on page 1.
      wv[0] = '{x: 10'd0,    y: 10'd0,    data: 16'h1234, sram: 1'b1, addr: {1'b1, 9'd0,   10'd0},   gap: 4};
      wv[1] = '{x: 10'd639,  y: 10'd479,  data: 16'h5A5A, sram: 1'b1, addr: 20'hF7E7F,                gap: 4};
      wv[2] = '{x: 10'd640,  y: 10'd0,    data: 16'h0001, sram: 1'b0, addr: 20'h0,                    gap: 1};
      wv[3] = '{x: 10'd5,    y: 10'd480,  data: 16'h0002, sram: 1'b0, addr: 20'h0,                    gap: 1};
      wv[4] = '{x: 10'd1023, y: 10'd1023, data: 16'h0003, sram: 1'b0, addr: 20'h0,                    gap: 1};
      wv[5] = '{x: 10'd321,  y: 10'd123,  data: 16'hA5A5, sram: 1'b1, addr: 20'h9ED41,                gap: 4};

      bus.line_req = 0; bus.line_y = 0; bus.fifo_full = 0; bus.wr_valid = 0;
      bus.wr_x = 0; bus.wr_y = 0; bus.wr_data = 0; bus.frame_done = 0; bus.vblank = 0;

      // Reset and idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {bus.SRAM_CE_N, bus.SRAM_UB_N, bus.SRAM_LB_N, bus.SRAM_OE_N, bus.SRAM_WE_N}, 5'b11111);
      chk("rst_dq_oe", bus.SRAM_DQ_oe, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_strobes", {bus.SRAM_CE_N, bus.SRAM_UB_N, bus.SRAM_LB_N, bus.SRAM_OE_N, bus.SRAM_WE_N}, 5'b11111);
      chk("idle_addr", bus.SRAM_ADDR, 0);
      chk("idle_flip_page", bus.flip_page, 0);
      chk("idle_wr_ready", bus.wr_ready, 1);
      chk("idle_pulses", {bus.fifo_we, bus.line_done, bus.line_err}, 3'b000);
      chk("idle_state", dbg_state, 0);
      tick();

      // Write vector table
      for (int i = 0; i < 6; i++) begin
         do_write(wv[i].x, wv[i].y, wv[i].data, gap);
         chk($sformatf("wv%0d_ready_gap", i), gap, wv[i].gap);
         repeat (2) tick();
         if (wv[i].sram) check_write($sformatf("wv%0d", i), wv[i].addr, wv[i].data);
         else chk($sformatf("wv%0d_no_access", i), wr_obs_q.size(), wr_rd_idx);
      end

      // Full line, then a line with a 10-cycle FIFO stall over pixel 100
      run_line("line5", 10'd5, 1'b0, 0, 0, H_RES, 0, 0, 1921, hs_c);
      repeat (2) tick();
      run_line("stall", 10'd6, 1'b0, 301, 10, 100, 8, 0, 1929, hs_c);
      repeat (2) tick();

      // Line request and write offered together: line first, write accepted on the done cycle
      bus.wr_x = 10'd10; bus.wr_y = 10'd20; bus.wr_data = 16'hBEEF; bus.wr_valid = 1'b1;
      run_line("line_vs_wr", 10'd9, 1'b0, 0, 0, H_RES, 0, 0, 1921, hs_c);
      chk("line_vs_wr_hs_cycle", hs_c, 1921);
      repeat (6) tick();
      check_write("wr_after_line", {1'b1, 9'd20, 10'd10}, 16'hBEEF);

      // Flip held until vblank
      bus.frame_done = 1'b1;
      tick();
      bus.frame_done = 1'b0;
      @(negedge clk);
      chk("flip_pend_wr_ready", bus.wr_ready, 0);
      repeat (4) tick();
      @(negedge clk);
      chk("no_flip_without_vblank", bus.flip_page, 0);
      tick();
      bus.vblank = 1'b1;
      @(negedge clk);
      chk("flip_before_edge", bus.flip_page, 0);
      tick();
      bus.vblank = 1'b0;
      @(negedge clk);
      chk("flip_after_vblank", bus.flip_page, 1);
      chk("flip_wr_ready", bus.wr_ready, 1);
      tick();
      do_write(10'd10, 10'd20, 16'hCAFE, gap);
      repeat (2) tick();
      check_write("wr_page0", {1'b0, 9'd20, 10'd10}, 16'hCAFE);

      // Boundary lines on the flipped page, and a duplicate request mid-fetch
      run_line("line479", 10'd479, 1'b1, 0, 0, H_RES, 0, 0, 1921, hs_c);
      repeat (2) tick();
      run_line("line480", 10'd480, 1'b1, 0, 0, H_RES, 0, 0, 2, hs_c);
      repeat (2) tick();
      run_line("dup_req", 10'd5, 1'b1, 0, 0, H_RES, 0, 50, 1921, hs_c);
      repeat (2) tick();

      // Reset asserted in the middle of a write
      bus.wr_x = 10'd1; bus.wr_y = 10'd2; bus.wr_data = 16'h7777; bus.wr_valid = 1'b1;
      @(negedge clk);
      chk("rst_wr_ready", bus.wr_ready, 1);
      tick();
      bus.wr_valid = 1'b0;
      #2;
      chk("mid_write_we_low", bus.SRAM_WE_N, 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_strobes", {bus.SRAM_CE_N, bus.SRAM_UB_N, bus.SRAM_LB_N, bus.SRAM_OE_N, bus.SRAM_WE_N}, 5'b11111);
      chk("async_rst_dq_oe", bus.SRAM_DQ_oe, 0);
      chk("async_rst_addr", bus.SRAM_ADDR, 0);
      chk("async_rst_flip", bus.flip_page, 0);
      chk("async_rst_state", dbg_state, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      chk("write_burst_errs", burst_err, 0);
      chk("write_gap_errs", gap_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
